// File: rtl/cache_trace_pkg.sv
// ============================================================================
// Module      : cache_trace_pkg
// Description : Shared types and defaults for the cache trace driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_trace_pkg;

    localparam int ADDR_W_DEF  = 48;
    localparam int CNT_W_DEF   = 12;
    localparam int ENTRY_W_DEF = ADDR_W_DEF + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/cache_trace_driver_trace_buffer.sv
// ============================================================================
// Module      : trace_buffer
// Description : Trace storage, one synchronous write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_buffer #(
    parameter int DEPTH   = 64,
    parameter int PTR_W   = 6,
    parameter int ENTRY_W = 49
) (
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic [PTR_W-1:0]   i_wr_ptr,
    input  logic [ENTRY_W-1:0] i_wr_data,
    input  logic [PTR_W-1:0]   i_rd_ptr,
    output logic [ENTRY_W-1:0] o_rd_data
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_ptr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/cache_trace_driver.sv
// ============================================================================
// Module      : cache_trace_driver
// Description : Loads an address trace and replays it as paced cache requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_trace_driver
    import cache_trace_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 64,
    parameter int PTR_W  = 6,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load_en,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic              i_load_rw,
    input  logic              i_clear,
    input  logic              i_start,
    input  logic              i_loop,
    input  logic [7:0]        i_gap_cycles,
    output logic              o_req_valid,
    output logic [ADDR_W-1:0] o_req_addr,
    output logic              o_req_rw,
    input  logic              i_req_ready,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_full,
    output logic [PTR_W:0]    o_entry_count,
    output logic [CNT_W-1:0]  o_issued_count
);

    localparam int             c_ENTRY_W  = ADDR_W + 1;
    localparam logic [PTR_W:0] c_FULL_CNT = (PTR_W+1)'(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [PTR_W-1:0]    w_rptr_nxt;
    logic [PTR_W:0]      r_entry_count;
    logic [CNT_W-1:0]    r_issued;
    logic [ADDR_W-1:0]   r_req_addr;
    logic                r_req_rw;
    logic                r_loop;
    logic [7:0]          r_gap;
    logic [7:0]          r_gap_cnt;
    logic                r_abort_pend;
    logic                r_trace_end;
    logic [c_ENTRY_W-1:0] w_rd_data;

    logic w_idle;
    logic w_full;
    logic w_load;
    logic w_start;
    logic w_hs;
    logic w_last;
    logic w_req_load;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_full     = (r_entry_count == c_FULL_CNT);
    assign w_load     = w_idle & i_load_en & ~i_clear & ~w_full;
    assign w_start    = w_idle & i_start;
    assign w_hs       = (r_state == ST_ISSUE) & i_req_ready;
    assign w_last     = ({1'b0, r_rptr} == (r_entry_count - 1'b1));
    assign w_req_load = w_start | w_hs;

    trace_buffer #(
        .DEPTH   (DEPTH),
        .PTR_W   (PTR_W),
        .ENTRY_W (c_ENTRY_W)
    ) u_buf (
        .clk       (clk),
        .i_wr_en   (w_load),
        .i_wr_ptr  (r_wptr),
        .i_wr_data ({i_load_rw, i_load_addr}),
        .i_rd_ptr  (w_rptr_nxt),
        .o_rd_data (w_rd_data)
    );

    // The buffer is read at the pointer value about to be committed, so the
    // request register always holds the entry the read pointer will name.
    always_comb begin
        w_rptr_nxt = r_rptr;
        if (w_start) begin
            w_rptr_nxt = '0;
        end else if (w_hs) begin
            w_rptr_nxt = (w_last & r_loop) ? '0 : r_rptr + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = (i_clear || r_entry_count == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_hs) begin
                    if (r_abort_pend | i_clear) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_gap != 8'd0) begin
                        w_state_nxt = ST_GAP;
                    end else if (w_last & ~r_loop) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_GAP: begin
                if (i_clear) begin
                    w_state_nxt = ST_DONE;
                end else if (r_gap_cnt == 8'd1) begin
                    w_state_nxt = r_trace_end ? ST_DONE : ST_ISSUE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_entry_count <= '0;
            r_issued      <= '0;
            r_req_addr    <= '0;
            r_req_rw      <= 1'b0;
            r_loop        <= 1'b0;
            r_gap         <= 8'd0;
            r_gap_cnt     <= 8'd0;
            r_abort_pend  <= 1'b0;
            r_trace_end   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rptr  <= w_rptr_nxt;

            if (w_idle & i_clear) begin
                r_wptr        <= '0;
                r_entry_count <= '0;
            end else if (w_load) begin
                r_wptr        <= r_wptr + 1'b1;
                r_entry_count <= r_entry_count + 1'b1;
            end

            if (w_idle & (i_clear | i_start)) begin
                r_issued <= '0;
            end else if (w_hs && r_issued != '1) begin
                r_issued <= r_issued + 1'b1;
            end

            if (w_start) begin
                r_loop      <= i_loop;
                r_gap       <= i_gap_cycles;
                r_trace_end <= 1'b0;
            end

            if (w_req_load) begin
                {r_req_rw, r_req_addr} <= w_rd_data;
            end

            if (w_hs) begin
                r_gap_cnt   <= r_gap;
                r_trace_end <= w_last & ~r_loop;
            end else if (r_state == ST_GAP) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end

            if (r_state == ST_DONE) begin
                r_abort_pend <= 1'b0;
            end else if ((r_state == ST_ISSUE) & i_clear) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

    assign o_req_valid    = (r_state == ST_ISSUE);
    assign o_req_addr     = r_req_addr;
    assign o_req_rw       = r_req_rw;
    assign o_busy         = ~w_idle;
    assign o_done         = (r_state == ST_DONE);
    assign o_full         = w_full;
    assign o_entry_count  = r_entry_count;
    assign o_issued_count = r_issued;

endmodule

`default_nettype wire

// File: tb/tb_cache_trace_driver.sv
// ============================================================================
// Module      : tb_cache_trace_driver
// Description : Directed and randomized replay checks against a trace model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_trace_driver;

    localparam int ADDR_W = 48;
    localparam int DEPTH  = 64;
    localparam int PTR_W  = 6;
    localparam int CNT_W  = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_load_en;
    logic [ADDR_W-1:0] i_load_addr;
    logic              i_load_rw;
    logic              i_clear;
    logic              i_start;
    logic              i_loop;
    logic [7:0]        i_gap_cycles;
    logic              o_req_valid;
    logic [ADDR_W-1:0] o_req_addr;
    logic              o_req_rw;
    logic              i_req_ready;
    logic              o_busy;
    logic              o_done;
    logic              o_full;
    logic [PTR_W:0]    o_entry_count;
    logic [CNT_W-1:0]  o_issued_count;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] mdl_addr [$];
    logic              mdl_rw   [$];

    always #5 clk = ~clk;

    cache_trace_driver #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_load_en      (i_load_en),
        .i_load_addr    (i_load_addr),
        .i_load_rw      (i_load_rw),
        .i_clear        (i_clear),
        .i_start        (i_start),
        .i_loop         (i_loop),
        .i_gap_cycles   (i_gap_cycles),
        .o_req_valid    (o_req_valid),
        .o_req_addr     (o_req_addr),
        .o_req_rw       (o_req_rw),
        .i_req_ready    (i_req_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_full         (o_full),
        .o_entry_count  (o_entry_count),
        .o_issued_count (o_issued_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic rw);
        i_load_en   = 1'b1;
        i_load_addr = a;
        i_load_rw   = rw;
        step();
        i_load_en = 1'b0;
        if (mdl_addr.size() < DEPTH) begin
            mdl_addr.push_back(a);
            mdl_rw.push_back(rw);
        end
    endtask

    task automatic clear_buf();
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        mdl_addr.delete();
        mdl_rw.delete();
        chk("clear_entry_count", o_entry_count, 0);
    endtask

    // rmode: 0 ready always high, 1 random ready, 2 ready low 4 cycles on entry 2.
    // abort_at > 0: clear is raised while request abort_at+1 is stalled.
    task automatic replay(input int gap, input bit lp, input int abort_at, input int rmode);
        int n, k, cyc, last_hs, low_cnt, hold, exp_total, exp_lat;
        bit prev_stall, seen_done, rdy;
        logic [ADDR_W-1:0] prev_addr;
        n = mdl_addr.size();
        k = 0; cyc = 0; last_hs = -1000; low_cnt = 0; hold = 0;
        prev_stall = 1'b0; seen_done = 1'b0; prev_addr = '0;
        exp_total = (abort_at > 0) ? abort_at + 1 : n;
        exp_lat   = (abort_at > 0 || gap == 0) ? 1 : gap + 1;
        i_gap_cycles = 8'(gap);
        i_loop       = lp;
        i_start      = 1'b1;
        step();
        i_start = 1'b0;
        while (!seen_done && cyc < 3000) begin
            i_clear = 1'b0;
            if (o_done) begin
                seen_done = 1'b1;
                chk("total_handshakes", k, exp_total);
                chk("issued_at_done", o_issued_count, exp_total);
                if (n == 0) chk("empty_done_latency", cyc, 0);
                else        chk("done_latency", cyc - last_hs, exp_lat);
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", o_req_valid, 1);
                    chk("stall_addr", o_req_addr, prev_addr);
                end
                if (gap > 0 && abort_at == 0 && cyc - last_hs <= gap)
                    chk("gap_idle", o_req_valid, 0);
                if (o_req_valid) chk("valid_expected", k < exp_total, 1);
                rdy = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rmode == 2 && k == 1 && low_cnt < 4) begin
                    rdy = 1'b0;
                    low_cnt++;
                end
                if (abort_at > 0 && k == abort_at && o_req_valid && hold < 3) begin
                    rdy = 1'b0;
                    if (hold == 0) i_clear = 1'b1;
                    hold++;
                end
                i_req_ready = rdy;
                if (o_req_valid && rdy && n > 0) begin
                    chk("req_addr", o_req_addr, mdl_addr[k % n]);
                    chk("req_rw", o_req_rw, mdl_rw[k % n]);
                    if (rmode == 0 && abort_at == 0 && k > 0)
                        chk("spacing", cyc - last_hs, gap + 1);
                    last_hs = cyc;
                    k++;
                end
                prev_stall = o_req_valid && !rdy;
                prev_addr  = o_req_addr;
            end
            step();
            cyc++;
        end
        i_clear     = 1'b0;
        i_req_ready = 1'b0;
        chk("done_seen", seen_done, 1);
        chk("busy_after_done", o_busy, 0);
        chk("done_one_cycle", o_done, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_load_en = 1'b0; i_load_addr = '0; i_load_rw = 1'b0;
        i_clear = 1'b0; i_start = 1'b0; i_loop = 1'b0; i_gap_cycles = 8'd0;
        i_req_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_valid", o_req_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_full", o_full, 0);
        chk("rst_entry_count", o_entry_count, 0);
        chk("rst_issued", o_issued_count, 0);
        chk("rst_req_addr", o_req_addr, 0);
        chk("rst_req_rw", o_req_rw, 0);

        // Three-entry trace, back-to-back.
        load(48'h1000, 1'b0);
        load(48'h2040, 1'b1);
        load(48'h1000, 1'b0);
        chk("load3_count", o_entry_count, 3);
        replay(0, 1'b0, 0, 0);

        // Same trace with a 4-cycle stall on entry 2.
        replay(0, 1'b0, 0, 2);
        chk("stall_issued", o_issued_count, 3);

        // clear and load together: clear wins.
        i_clear = 1'b1; i_load_en = 1'b1; i_load_addr = 48'hdead;
        step();
        i_clear = 1'b0; i_load_en = 1'b0;
        mdl_addr.delete(); mdl_rw.delete();
        chk("clear_wins_count", o_entry_count, 0);
        chk("clear_issued", o_issued_count, 0);

        // Gap of 2 between handshakes.
        load(48'h1000, 1'b0);
        load(48'h2040, 1'b1);
        replay(2, 1'b0, 0, 0);

        // Looping replay aborted while the sixth request stalls.
        clear_buf();
        load(48'h2040, 1'b1);
        load(48'h1000, 1'b0);
        replay(0, 1'b1, 5, 0);
        chk("abort_issued", o_issued_count, 6);

        // Fill the buffer, try one extra load, replay everything.
        clear_buf();
        for (int i = 0; i < DEPTH; i++)
            load(ADDR_W'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)));
        chk("full_flag", o_full, 1);
        chk("full_count", o_entry_count, DEPTH);
        load(48'hbeef, 1'b1);
        chk("overflow_ignored", o_entry_count, DEPTH);
        replay(0, 1'b0, 0, 1);
        chk("full_issued", o_issued_count, DEPTH);

        // Empty buffer start.
        clear_buf();
        replay(0, 1'b0, 0, 0);

        // Randomized traces, gaps and ready patterns.
        for (int it = 0; it < 4; it++) begin
            int n;
            clear_buf();
            n = $urandom_range(1, 10);
            for (int i = 0; i < n; i++)
                load(ADDR_W'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)));
            chk("rand_count", o_entry_count, n);
            replay($urandom_range(0, 3), 1'b0, 0, 1);
        end

        // Asynchronous reset during ISSUE.
        clear_buf();
        load(48'h1000, 1'b0);
        load(48'h2040, 1'b1);
        load(48'h3080, 1'b0);
        i_loop = 1'b0; i_gap_cycles = 8'd0; i_start = 1'b1;
        step();
        i_start = 1'b0; i_req_ready = 1'b1;
        step();
        i_req_ready = 1'b0;
        step();
        chk("pre_rst_valid", o_req_valid, 1);
        chk("pre_rst_issued", o_issued_count, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", o_req_valid, 0);
        chk("async_rst_busy", o_busy, 0);
        chk("async_rst_issued", o_issued_count, 0);
        chk("async_rst_count", o_entry_count, 0);
        step();
        rst = 1'b0;
        mdl_addr.delete(); mdl_rw.delete();
        step();
        chk("post_rst_count", o_entry_count, 0);
        chk("post_rst_valid", o_req_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
